// File: rtl/lbus_initiator_if.sv
// Command/response stream and local-bus signals of the local-bus initiator.
// Both streams use valid/ready: a beat transfers on a rising edge where valid & ready are both 1; valid, once raised, holds its payload stable until that edge.
interface lbus_initiator_if #(
   parameter int AWIDTH = 8,
   parameter int XLEN   = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [1:0]        cmd_size;
   logic [AWIDTH-1:0] cmd_addr;
   logic [XLEN-1:0]   cmd_wdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_rdata;
   logic              rsp_err;

   logic              sel;
   logic [AWIDTH-1:0] addr;
   logic [2:0]        we;
   logic [XLEN-1:0]   wdata;
   logic [XLEN-1:0]   rdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, rsp_ready, rdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel, addr, we, wdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_size, cmd_addr, cmd_wdata, rsp_ready, rdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel, addr, we, wdata
   );
endinterface

// File: rtl/lbus_initiator.sv
// Local-bus initiator: one command -> one single-cycle bus access -> one response.
// Bus outputs are registered; the registered bus fields double as the stored command.
module lbus_initiator #(
   parameter int AWIDTH = 8,
   parameter int XLEN   = 32
) (
   input  logic               clk,
   input  logic               rst,
   lbus_initiator_if.master   bus,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_e;

   state_e            state, state_d;
   logic              sel_q, sel_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [2:0]        we_q, we_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;

   logic              cmd_legal;
   logic [XLEN-1:0]   wdata_masked;
   logic [XLEN-1:0]   rdata_shifted;
   logic [XLEN-1:0]   rdata_extracted;

   always_comb begin
      unique case (bus.cmd_size)
         2'b00:   cmd_legal = 1'b1;
         2'b01:   cmd_legal = ~bus.cmd_addr[0];
         2'b10:   cmd_legal = (bus.cmd_addr[1:0] == 2'b00);
         default: cmd_legal = 1'b0;
      endcase
   end

   // Clearing bits above the access size keeps unaccessed lanes at zero.
   always_comb begin
      unique case (bus.cmd_size)
         2'b00:   wdata_masked = {{(XLEN-8){1'b0}}, bus.cmd_wdata[7:0]};
         2'b01:   wdata_masked = {{(XLEN-16){1'b0}}, bus.cmd_wdata[15:0]};
         default: wdata_masked = bus.cmd_wdata;
      endcase
   end

   assign rdata_shifted = bus.rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      unique case (we_q[1:0])
         2'b00:   rdata_extracted = {{(XLEN-8){1'b0}}, rdata_shifted[7:0]};
         2'b01:   rdata_extracted = {{(XLEN-16){1'b0}}, rdata_shifted[15:0]};
         default: rdata_extracted = bus.rdata;
      endcase
   end

   always_comb begin
      state_d     = state;
      sel_d       = 1'b0;
      addr_d      = '0;
      we_d        = 3'b000;
      wdata_d     = '0;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      unique case (state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               state_d = S_ACCESS;
               if (cmd_legal) begin
                  sel_d   = 1'b1;
                  addr_d  = bus.cmd_addr;
                  we_d    = {bus.cmd_write, bus.cmd_size};
                  wdata_d = wdata_masked << {bus.cmd_addr[1:0], 3'b000};
               end
            end
         end
         S_ACCESS: begin
            // An illegal command never raised sel, so sel_q is the legality flag here.
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ~sel_q;
            rsp_rdata_d = (sel_q && !we_q[2]) ? rdata_extracted : '0;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               state_d     = S_IDLE;
               rsp_valid_d = 1'b0;
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         sel_q       <= 1'b0;
         addr_q      <= '0;
         we_q        <= 3'b000;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state       <= state_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.cmd_ready = (state == S_IDLE) && !rst;
   assign bus.sel       = sel_q;
   assign bus.addr      = addr_q;
   assign bus.we        = we_q;
   assign bus.wdata     = wdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_lbus_initiator.sv
// Directed and randomized bench for lbus_initiator with a response scoreboard.
module tb_lbus_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  dbg_state;
   logic [31:0] resp_word;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [32:0] exp_q[$];

   lbus_initiator_if #(.AWIDTH(8), .XLEN(32)) bif ();

   lbus_initiator #(.AWIDTH(8), .XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bif),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Responder: data only meaningful while selected.
   assign bif.rdata = bif.sel ? resp_word : 32'hFFFF_FFFF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_cmd(input logic w, input logic [1:0] sz, input logic [7:0] a,
                            input logic [31:0] wd);
      bif.cmd_valid = 1'b1;
      bif.cmd_write = w;
      bif.cmd_size  = sz;
      bif.cmd_addr  = a;
      bif.cmd_wdata = wd;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic do_cmd(input string tag, input logic w, input logic [1:0] sz,
                         input logic [7:0] a, input logic [31:0] wd,
                         input logic [31:0] rw, input int bp);
      logic        ok;
      logic [31:0] mask, ew, er;
      logic [2:0]  ewe;
      logic [7:0]  ea;
      logic [32:0] e;
      int          k;
      ok   = (sz == 2'b00) || (sz == 2'b01 && !a[0]) || (sz == 2'b10 && a[1:0] == 2'b00);
      mask = (sz == 2'b00) ? 32'h0000_00FF : (sz == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      ew   = ok ? ((wd & mask) << (8 * a[1:0])) : 32'h0;
      er   = (ok && !w) ? ((rw >> (8 * a[1:0])) & mask) : 32'h0;
      ewe  = ok ? {w, sz} : 3'b000;
      ea   = ok ? a : 8'h00;
      exp_q.push_back({~ok, er});

      resp_word = rw;
      drive_cmd(w, sz, a, wd);
      #1;
      k = 0;
      while (!bif.cmd_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({tag, ":cmd_ready_idle"}, 32'(bif.cmd_ready), 32'h1);
      @(posedge clk);
      #1;
      bif.cmd_valid = 1'b0;
      if (bp > 0) bif.rsp_ready = 1'b0;

      @(negedge clk);
      chk({tag, ":sel"},   32'(bif.sel),   32'(ok));
      chk({tag, ":addr"},  32'(bif.addr),  32'(ea));
      chk({tag, ":we"},    32'(bif.we),    32'(ewe));
      chk({tag, ":wdata"}, bif.wdata,      ew);
      chk({tag, ":cmd_ready_access"}, 32'(bif.cmd_ready), 32'h0);

      @(negedge clk);
      chk({tag, ":rsp_valid"}, 32'(bif.rsp_valid), 32'h1);
      chk({tag, ":sel_resp"},  32'(bif.sel),       32'h0);
      if (bp > 0) begin
         bif.cmd_valid = 1'b1;
         for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({tag, ":bp_valid"}, 32'(bif.rsp_valid), 32'h1);
            chk({tag, ":bp_rdata"}, bif.rsp_rdata,      er);
            chk({tag, ":bp_ready"}, 32'(bif.cmd_ready), 32'h0);
            chk({tag, ":bp_sel"},   32'(bif.sel),       32'h0);
         end
         bif.cmd_valid = 1'b0;
         bif.rsp_ready = 1'b1;
      end

      chk({tag, ":q_nonempty"}, 32'(exp_q.size() != 0), 32'h1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h0;
      chk({tag, ":rsp_rdata"}, bif.rsp_rdata,     e[31:0]);
      chk({tag, ":rsp_err"},   32'(bif.rsp_err),  32'(e[32]));

      @(posedge clk);
      #1;
      @(negedge clk);
      chk({tag, ":rsp_done"},  32'(bif.rsp_valid), 32'h0);
      chk({tag, ":ready_back"}, 32'(bif.cmd_ready), 32'h1);
   endtask

   initial begin
      logic        rw_w;
      logic [1:0]  rw_sz;
      logic [7:0]  rw_a;
      logic [31:0] rw_d;

      rst           = 1'b1;
      resp_word     = 32'h0;
      bif.cmd_valid = 1'b0;
      bif.cmd_write = 1'b0;
      bif.cmd_size  = 2'b00;
      bif.cmd_addr  = 8'h00;
      bif.cmd_wdata = 32'h0;
      bif.rsp_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst:sel",       32'(bif.sel),       32'h0);
      chk("rst:addr",      32'(bif.addr),      32'h0);
      chk("rst:we",        32'(bif.we),        32'h0);
      chk("rst:wdata",     bif.wdata,          32'h0);
      chk("rst:rsp_valid", 32'(bif.rsp_valid), 32'h0);
      chk("rst:rsp_rdata", bif.rsp_rdata,      32'h0);
      chk("rst:rsp_err",   32'(bif.rsp_err),   32'h0);
      chk("rst:cmd_ready", 32'(bif.cmd_ready), 32'h0);
      rst = 1'b0;
      #1;
      chk("rst:cmd_ready_release", 32'(bif.cmd_ready), 32'h1);
      @(negedge clk);

      do_cmd("word_rd",    1'b0, 2'b10, 8'h10, 32'h0,         32'h0000_A55A, 0);
      do_cmd("byte_rd_l1", 1'b0, 2'b00, 8'h11, 32'h0,         32'h0000_3C00, 0);
      do_cmd("byte_wr_l2", 1'b1, 2'b00, 8'h22, 32'h0000_00F1, 32'h1234_5678, 0);
      do_cmd("half_rd_hi", 1'b0, 2'b01, 8'h12, 32'h0,         32'hBEEF_1234, 0);
      do_cmd("half_wr_hi", 1'b1, 2'b01, 8'h32, 32'h0000_C0DE, 32'h0,         0);
      do_cmd("word_wr",    1'b1, 2'b10, 8'h40, 32'hDEAD_BEEF, 32'h0,         0);
      do_cmd("byte_rd_l3", 1'b0, 2'b00, 8'h07, 32'h0,         32'h9A00_0000, 0);
      do_cmd("mis_word",   1'b0, 2'b10, 8'h06, 32'h0,         32'hFFFF_FFFF, 0);
      do_cmd("mis_half",   1'b1, 2'b01, 8'h03, 32'h0000_ABCD, 32'h0,         0);
      do_cmd("bad_size",   1'b0, 2'b11, 8'h00, 32'h0,         32'h1111_1111, 0);
      do_cmd("backpress",  1'b0, 2'b01, 8'h2A, 32'h0,         32'h5566_7788, 5);

      // Reset during ACCESS: the command is dropped silently.
      resp_word = 32'hCAFE_F00D;
      drive_cmd(1'b0, 2'b10, 8'h20, 32'h0);
      @(posedge clk);
      #1;
      bif.cmd_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_acc:sel_before", 32'(bif.sel), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_acc:sel",       32'(bif.sel),       32'h0);
      chk("rst_acc:rsp_valid", 32'(bif.rsp_valid), 32'h0);
      chk("rst_acc:cmd_ready", 32'(bif.cmd_ready), 32'h1);
      repeat (3) begin
         @(negedge clk);
         chk("rst_acc:no_rsp", 32'(bif.rsp_valid), 32'h0);
      end

      // Reset during RESP with the response held back.
      drive_cmd(1'b0, 2'b00, 8'h01, 32'h0);
      @(posedge clk);
      #1;
      bif.cmd_valid = 1'b0;
      bif.rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_rsp:valid_before", 32'(bif.rsp_valid), 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bif.rsp_ready = 1'b1;
      @(negedge clk);
      chk("rst_rsp:rsp_valid", 32'(bif.rsp_valid), 32'h0);
      chk("rst_rsp:rsp_rdata", bif.rsp_rdata,      32'h0);
      chk("rst_rsp:sel",       32'(bif.sel),       32'h0);
      chk("rst_rsp:cmd_ready", 32'(bif.cmd_ready), 32'h1);
      repeat (3) begin
         @(negedge clk);
         chk("rst_rsp:no_rsp", 32'(bif.rsp_valid), 32'h0);
      end

      do_cmd("after_rst", 1'b0, 2'b10, 8'h44, 32'h0, 32'h0BAD_F00D, 0);

      for (int n = 0; n < 12; n++) begin
         rw_w  = 1'($urandom_range(0, 1));
         rw_sz = 2'($urandom_range(0, 3));
         rw_a  = 8'($urandom_range(0, 255));
         rw_d  = $urandom;
         if (rw_sz == 2'b00) rw_d = rw_d & 32'h0000_00FF;
         if (rw_sz == 2'b01) rw_d = rw_d & 32'h0000_FFFF;
         do_cmd("rand", rw_w, rw_sz, rw_a, rw_d, $urandom, $urandom_range(0, 2));
      end

      chk("q_drained", exp_q.size(), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/lbus_initiator.md
# lbus_initiator

Local-bus initiator that turns a valid/ready command stream into single-cycle accesses on the peripheral local bus, the bus that GPIO and the other register blocks respond to. It drives `sel/addr/we/wdata` and samples `rdata`. It aligns write data onto byte lanes and extracts/zero-extends read data. It returns one response per command. It sits between a bus master (core load/store unit or debug bridge) and the peripheral address decoder, with one transaction outstanding at a time.

## Interface
- `AWIDTH`, 8 — local-bus address width (byte address).
- `XLEN`, 32 — data width; fixed at 32 for lane logic.
- `clk` in 1 — the single clock; all logic rising-edge.
- `rst` in 1 — reset, synchronous, active-high.
- `cmd_valid` in 1 — command present.
- `cmd_ready` out 1 — command accepted when `cmd_valid & cmd_ready`.
- `cmd_write` in 1 — 1 = write, 0 = read.
- `cmd_size` in 2 — 2'b00 byte, 2'b01 halfword, 2'b10 word; 2'b11 is illegal.
- `cmd_addr` in AWIDTH — byte address.
- `cmd_wdata` in XLEN — write data, right-justified (LSB-aligned).
- `rsp_valid` out 1 — response present.
- `rsp_ready` in 1 — response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata` out XLEN — read data, right-justified and zero-extended; 0 for writes and errors.
- `rsp_err` out 1 — misaligned access or illegal size; no bus access was made.
- `sel` out 1 — local-bus select.
- `addr` out AWIDTH — local-bus address.
- `we` out 3 — `{write, size}`; `we[2]`=1 write, `we[1:0]` = size.
- `wdata` out XLEN — lane-aligned write data.
- `rdata` in XLEN — responder read data, combinational on `sel/addr`, valid in the same cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `cmd_ready`=1. On handshake, register the command and go to ACCESS.
- ACCESS (exactly one cycle): if the command is legal, drive `sel`=1, `addr`=cmd_addr, `we`={cmd_write,cmd_size}, `wdata`=lane-aligned data. For reads, capture lane-extracted `rdata` at the end of the cycle. Always go to RESP.
- RESP: `rsp_valid`=1 and hold `rsp_rdata/rsp_err` stable until `rsp_ready`. On handshake, go to IDLE.
- Legality:
  - size 2'b11 is illegal.
  - Halfword with `addr[0]`=1 is illegal.
  - Word with `addr[1:0]`≠0 is illegal.
  - Illegal command → `sel` stays 0 in ACCESS, `rsp_err`=1, `rsp_rdata`=0.
- Write lane alignment: `wdata = cmd_wdata << (8*addr[1:0])`, truncated to XLEN. Bytes outside the accessed lanes are 0.
- Read extraction: `t = rdata >> (8*addr[1:0])`.
  - byte → `{24'h0, t[7:0]}`
  - halfword → `{16'h0, t[15:0]}`
  - word → `rdata`
- Write response: `rsp_rdata`=0, `rsp_err`=0.
- When `sel`=0, `addr`, `we` and `wdata` are driven to 0 (no stale values on the bus).
- Reset: `rst` in any state forces IDLE on the next edge; an in-flight command or pending response is dropped without a response.

## Timing
- Reset values (cycle after `rst` sampled high):
  - `sel`=0, `addr`=0, `we`=0, `wdata`=0.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `cmd_ready`=0 while `rst`=1; `cmd_ready`=1 in the first cycle with `rst`=0.
- Command handshake in cycle N → `sel` high in N+1 (registered outputs) → `rsp_valid` high in N+2.
- With `rsp_ready` held at 1: `rsp_valid` lasts 1 cycle (N+2), `cmd_ready` returns in N+3, and throughput is one transaction per 3 cycles.
- `cmd_ready`=0 in ACCESS and RESP. `cmd_valid` is ignored there.
- `rsp_ready` asserted while `rsp_valid`=0 has no effect.
- `rsp_valid`, once high, never drops without a handshake except on `rst`.
- `sel` is high for at most one cycle per command, and never two cycles in a row.

## Test plan
- Word read: cmd read, size 2'b10, addr 8'h10, responder `rdata`=32'h0000_A55A → `sel`=1 for one cycle at N+1 with `we`=3'b010; rsp at N+2 with `rsp_rdata`=32'h0000_A55A, `rsp_err`=0.
- Byte read, lane 1: addr 8'h11, size 2'b00, `rdata`=32'h0000_3C00 → `rsp_rdata`=32'h0000_003C.
- Byte write, lane 2: addr 8'h22, `cmd_wdata`=32'h0000_00F1 → `wdata`=32'h00F1_0000, `we`=3'b100, `addr`=8'h22; `rsp_rdata`=0.
- Misaligned: word read at 8'h06, halfword write at 8'h03, size 2'b11 at 8'h00 → `sel` never asserted; each gives `rsp_err`=1 and `rsp_rdata`=0.
- Backpressure: `rsp_ready`=0 for 5 cycles → `rsp_valid`/`rsp_rdata` stable for all 5; `cmd_ready`=0 throughout even with `cmd_valid`=1; the next command is accepted only after the response handshake.
- Reset mid-op: `rst` pulsed in the ACCESS cycle and again in RESP → next cycle `sel`=0 and `rsp_valid`=0; no response is ever issued for the dropped command; a new read completes normally afterwards.
